// File: rtl/output_pkt_arbiter_pkg.sv
// rtl/output_pkt_arbiter_pkg.sv - shared types and constants for the output packet arbiter
package output_pkt_arbiter_pkg;
   localparam int WORD_W = 64;
   localparam int DEF_STALL_LIMIT = 1024;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARB  = 2'd1,
      XFER = 2'd2
   } state_t;
endpackage

// File: rtl/output_pkt_arbiter_rr_pick.sv
// rtl/output_pkt_arbiter_rr_pick.sv - round-robin picker: first set request at or above ptr, modulo N
module output_pkt_arbiter_rr_pick #(
   parameter int N = 4
) (
   input  logic [N-1:0] req,
   input  logic [2:0]   ptr,
   output logic [N-1:0] onehot,
   output logic [2:0]   idx,
   output logic         any
);
   logic [7:0] req_ext;
   logic [7:0] onehot_ext;

   assign req_ext = 8'(req);
   assign onehot  = onehot_ext[N-1:0];

   always_comb begin
      logic [2:0] c;
      onehot_ext = '0;
      idx        = '0;
      any        = 1'b0;
      c          = '0;
      for (int k = 0; k < N; k++) begin
         c = 3'((int'(ptr) + k) % N);
         if (!any && req_ext[c]) begin
            any           = 1'b1;
            onehot_ext[c] = 1'b1;
            idx           = c;
         end
      end
   end
endmodule

// File: rtl/output_pkt_arbiter.sv
// rtl/output_pkt_arbiter.sv - packet-granular round-robin sharing of the 64-bit output FIFO write path
module output_pkt_arbiter
   import output_pkt_arbiter_pkg::*;
#(
   parameter int N           = 4,
   parameter int STALL_LIMIT = DEF_STALL_LIMIT,
   parameter int CNT_W       = 16
) (
   input  logic                CLK,
   input  logic                RESET_N,
   input  logic                en,
   input  logic [N*WORD_W-1:0] req_dout,
   input  logic [N-1:0]        req_empty,
   input  logic [N-1:0]        req_pkt_end,
   output logic [N-1:0]        req_rd_en,
   output logic [WORD_W-1:0]   dout,
   output logic                wr_en,
   output logic                pkt_end,
   input  logic                full,
   output logic [2:0]          grant_idx,
   output logic                busy,
   output logic                err_stall,
   output logic [CNT_W-1:0]    words_last
);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t             state;
   logic [2:0]         rr_ptr;
   logic [N-1:0]       grant_oh;
   logic [CNT_W-1:0]   word_cnt;
   logic [CNT_W-1:0]   stall_cnt;

   logic [N-1:0]       nonempty;
   logic [N-1:0]       pick_onehot;
   logic [2:0]         pick_idx;
   logic               pick_any;
   logic [WORD_W-1:0]  sel_word;
   logic               head_ok;
   logic               head_end;
   logic               xfer;

   assign nonempty = ~req_empty;

   output_pkt_arbiter_rr_pick #(.N(N)) u_rr_pick (
      .req    (nonempty),
      .ptr    (rr_ptr),
      .onehot (pick_onehot),
      .idx    (pick_idx),
      .any    (pick_any)
   );

   // Granted requester is muxed by its one-hot so no index-width arithmetic is needed.
   always_comb begin
      sel_word = '0;
      for (int i = 0; i < N; i++) begin
         if (grant_oh[i]) sel_word = sel_word | req_dout[i*WORD_W +: WORD_W];
      end
   end

   assign head_ok   = |(grant_oh & nonempty);
   assign head_end  = |(grant_oh & req_pkt_end);
   assign xfer      = (state == XFER) && head_ok && !full;
   assign dout      = (state == XFER) ? sel_word : '0;
   assign wr_en     = xfer;
   assign pkt_end   = xfer && head_end;
   assign req_rd_en = xfer ? grant_oh : '0;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state      <= IDLE;
         rr_ptr     <= '0;
         grant_idx  <= '0;
         grant_oh   <= '0;
         busy       <= 1'b0;
         err_stall  <= 1'b0;
         words_last <= '0;
         word_cnt   <= '0;
         stall_cnt  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (en && |nonempty) state <= ARB;
            end
            ARB: begin
               if (pick_any) begin
                  state     <= XFER;
                  grant_idx <= pick_idx;
                  grant_oh  <= pick_onehot;
                  busy      <= 1'b1;
                  stall_cnt <= '0;
               end else begin
                  state <= IDLE;
               end
            end
            XFER: begin
               if (xfer) begin
                  stall_cnt <= '0;
                  if (head_end) begin
                     words_last <= (word_cnt == CNT_MAX) ? CNT_MAX : word_cnt + 1'b1;
                     word_cnt   <= '0;
                     rr_ptr     <= 3'((int'(grant_idx) + 1) % N);
                     busy       <= 1'b0;
                     state      <= (en && |nonempty) ? ARB : IDLE;
                  end else if (word_cnt != CNT_MAX) begin
                     word_cnt <= word_cnt + 1'b1;
                  end
               end else if (!head_ok && !full) begin
                  // Grant is kept through a stall; releasing it would interleave packets.
                  if (int'(stall_cnt) < STALL_LIMIT && stall_cnt != CNT_MAX)
                     stall_cnt <= stall_cnt + 1'b1;
                  if (int'(stall_cnt) >= STALL_LIMIT - 1) err_stall <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/output_pkt_arbiter.md
Name: output_pkt_arbiter

Overview:
- Shares the single 64-bit application output path (the packet-aware output FIFO write side) between N independent application units, e.g. multiple DES cores.
- Grants are per whole packet: once a unit is granted, it keeps the path until its word flagged pkt_end has been written.
- Requesters are served round-robin.
- Sits between the application units and the output FIFO in the CLK_APP domain. Stall status goes to app_status via VCR.

Parameters:
- N, 4: number of requesters (2..8).
- STALL_LIMIT, 1024: cycles a granted requester may sit empty mid-packet before err_stall is set.
- CNT_W, 16: width of the per-grant word counter and the stall counter.

Ports:
- CLK  in  1  application clock.
- RESET_N  in  1  asynchronous active-low reset.
- en  in  1  allow new grants (from app_mode); does not abort a packet in progress.
- req_dout  in  N*64  requester FWFT data; requester i occupies bits [64*i+63:64*i].
- req_empty  in  N  requester FIFO empty.
- req_pkt_end  in  N  current head word of requester i is the last word of its packet.
- req_rd_en  out  N  pop strobe to requester i.
- dout  out  64  to output FIFO din.
- wr_en  out  1  to output FIFO wr_en.
- pkt_end  out  1  to output FIFO pkt_end; qualified by wr_en.
- full  in  1  output FIFO full.
- grant_idx  out  3  index of the current or last granted requester.
- busy  out  1  packet in progress.
- err_stall  out  1  sticky; set when a stall timeout occurs.
- words_last  out  CNT_W  word count of the last completed packet.

Behaviour:
- Reset (RESET_N low, asynchronous):
  - state = IDLE; rr_ptr = 0; grant_idx = 0.
  - busy = 0, err_stall = 0, words_last = 0, stall counter = 0, word counter = 0.
  - wr_en, pkt_end and req_rd_en are combinational and are forced to 0 in IDLE.
  - Asserting reset mid-packet abandons the packet. Downstream FIFO reset is the system's responsibility; it shares the same RESET.
- States:
  - IDLE → ARB when en = 1 and any req_empty[i] = 0.
  - ARB (1 cycle):
    - Select the first non-empty requester searching from rr_ptr upward, modulo N.
    - Latch grant_idx; busy = 1 from the next cycle.
    - If all requesters went empty in this cycle, return to IDLE.
  - XFER:
    - xfer = !req_empty[g] && !full.
    - dout = req_dout[g]; wr_en = xfer; pkt_end = xfer && req_pkt_end[g].
    - req_rd_en[g] = xfer; all other req_rd_en bits = 0.
    - Zero-latency combinational pass-through; one word per cycle at most.
    - Word counter increments on each xfer.
    - On xfer with req_pkt_end[g]:
      - words_last = counter + 1; counter clears.
      - rr_ptr = (g + 1) mod N; busy = 0.
      - Next state is ARB if en and any requester is non-empty, else IDLE.
- Arbitration latency: one ARB bubble cycle between packets. First word of the next packet is written 2 cycles after the pkt_end word at the earliest.
- full high: no pop and no write. The state is held indefinitely with no timeout, since backpressure is legitimate.
- Stall: in XFER with req_empty[g] = 1 and full = 0, the stall counter increments; any xfer clears it.
  - When the counter reaches STALL_LIMIT: err_stall = 1, sticky until reset, and the counter saturates.
  - The grant is still held, because dropping it would interleave packets.
- en deasserted mid-packet: the current packet completes and the block then parks in IDLE.
- Counter widths: both counters saturate at 2^CNT_W - 1 and never wrap.
- Single-word packets (pkt_end on the first word) are legal.

Decomposition:
- Shared package holds:
  - word width 64;
  - state encoding IDLE = 2'd0, ARB = 2'd1, XFER = 2'd2;
  - default STALL_LIMIT.
- One sub-module, rr_pick: combinational N-bit request vector plus rr_ptr in, one-hot and index of the selected requester out. It is reusable by future input-side distributors.

Test Plan:
- Single requester 0 sends a 3-word packet (pkt_end on word 3), full = 0 → words written on 3 consecutive cycles; pkt_end only with word 3; words_last = 3; busy falls; state IDLE.
- Requesters 0 and 2 each hold a 2-word packet, rr_ptr = 0 → order: r0 w0, r0 w1, bubble, r2 w0, r2 w1; then rr_ptr = 3; grant_idx = 2.
- Requester 1 packet of 4 words with full high for 5 cycles after word 2 → no wr_en and no req_rd_en[1] during those cycles; words 3–4 follow; no loss or duplication; err_stall stays 0.
- Requester 3 empties after word 1 of a 2-word packet, with STALL_LIMIT = 8 → err_stall rises exactly on the 8th empty cycle; grant is held; requester 1 becomes non-empty meanwhile and is not interleaved.
- en dropped during the second word of a 3-word packet, other requesters non-empty → packet completes and the block stays in IDLE; en = 1 again → ARB on the next cycle.
- RESET_N pulsed low mid-XFER → all outputs 0 immediately, without waiting for a CLK edge; after release, arbitration restarts from requester 0.
